// File: rtl/watch_pkg.sv
// Shared calendar definitions for the watch counter, setting and display blocks.
package watch_pkg;

  localparam int unsigned FIELD_W = 8;

  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] YEAR_MAX  = 8'd99;

  // Bit positions of the fields inside the packed 48-bit time bus.
  localparam int unsigned YEAR_LSB  = 40;
  localparam int unsigned MONTH_LSB = 32;
  localparam int unsigned DAY_LSB   = 24;
  localparam int unsigned HOUR_LSB  = 16;
  localparam int unsigned MIN_LSB   = 8;
  localparam int unsigned SEC_LSB   = 0;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } cal_t;

  // Calendar value after reset: 2000-01-01 00:00:00.
  localparam cal_t RST_CAL = '{year: 8'd0, month: 8'd1, day: 8'd1,
                               hour: 8'd0, minute: 8'd0, second: 8'd0};

endpackage

// File: rtl/month_days.sv
// Days-in-month lookup; leap years are those with year divisible by 4.
module month_days
  import watch_pkg::*;
(
  input  logic [7:0] month,
  input  logic [7:0] year,
  output logic [4:0] dim
);

  // Month table with February depending on the leap-year test.
  always_comb begin
    dim = 5'd31;
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: dim = 5'd30;
      8'd2:                    dim = ((year & 8'd3) == 8'd0) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/watch_counter.sv
// Free-running calendar timekeeper with a one-second prescaler and a load port.
module watch_counter
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_time,
  input  logic [47:0] bin_time,
  output logic [7:0]  year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic        sec_tick
);

  localparam int unsigned    PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  cal_t             cur;
  cal_t             nxt;
  cal_t             ld;
  logic [4:0]       cur_dim;
  logic [4:0]       ld_dim;

  logic [7:0] raw_year, raw_month, raw_day, raw_hour, raw_min, raw_sec;
  logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec;

  assign raw_year  = bin_time[YEAR_LSB  +: FIELD_W];
  assign raw_month = bin_time[MONTH_LSB +: FIELD_W];
  assign raw_day   = bin_time[DAY_LSB   +: FIELD_W];
  assign raw_hour  = bin_time[HOUR_LSB  +: FIELD_W];
  assign raw_min   = bin_time[MIN_LSB   +: FIELD_W];
  assign raw_sec   = bin_time[SEC_LSB   +: FIELD_W];

  assign tick = (pre == PRE_LAST);

  month_days u_cur_dim (.month(cur.month), .year(cur.year), .dim(cur_dim));
  month_days u_ld_dim  (.month(ld_month),  .year(ld_year),  .dim(ld_dim));

  // Clamp load fields into range; month/year first since day depends on them.
  always_comb begin
    ld_sec   = (raw_sec  > SEC_MAX)  ? SEC_MAX  : raw_sec;
    ld_min   = (raw_min  > MIN_MAX)  ? MIN_MAX  : raw_min;
    ld_hour  = (raw_hour > HOUR_MAX) ? HOUR_MAX : raw_hour;
    ld_year  = (raw_year > YEAR_MAX) ? YEAR_MAX : raw_year;
    ld_month = raw_month;
    if (raw_month == 8'd0) begin
      ld_month = 8'd1;
    end else if (raw_month > MONTH_MAX) begin
      ld_month = MONTH_MAX;
    end
    ld_day = raw_day;
    if (raw_day == 8'd0) begin
      ld_day = 8'd1;
    end else if (raw_day > {3'b000, ld_dim}) begin
      ld_day = {3'b000, ld_dim};
    end
    ld = '{year: ld_year, month: ld_month, day: ld_day,
           hour: ld_hour, minute: ld_min, second: ld_sec};
  end

  // One-second advance with the full carry cascade; >= makes stray values roll over.
  always_comb begin
    nxt = cur;
    if (cur.second >= SEC_MAX) begin
      nxt.second = '0;
      if (cur.minute >= MIN_MAX) begin
        nxt.minute = '0;
        if (cur.hour >= HOUR_MAX) begin
          nxt.hour = '0;
          if (cur.day >= {3'b000, cur_dim}) begin
            nxt.day = 8'd1;
            if (cur.month >= MONTH_MAX) begin
              nxt.month = 8'd1;
              nxt.year  = (cur.year >= YEAR_MAX) ? '0 : cur.year + 8'd1;
            end else begin
              nxt.month = cur.month + 8'd1;
            end
          end else begin
            nxt.day = cur.day + 8'd1;
          end
        end else begin
          nxt.hour = cur.hour + 8'd1;
        end
      end else begin
        nxt.minute = cur.minute + 8'd1;
      end
    end else begin
      nxt.second = cur.second + 8'd1;
    end
  end

  // Calendar, prescaler and tick registers; load has priority over a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= RST_CAL;
      pre      <= '0;
      sec_tick <= 1'b0;
    end else if (en_time) begin
      cur      <= ld;
      pre      <= '0;
      sec_tick <= 1'b0;
    end else if (tick) begin
      cur      <= nxt;
      pre      <= '0;
      sec_tick <= 1'b1;
    end else begin
      pre      <= pre + PRE_W'(1);
      sec_tick <= 1'b0;
    end
  end

  assign year   = cur.year;
  assign month  = cur.month;
  assign day    = cur.day;
  assign hour   = cur.hour;
  assign minute = cur.minute;
  assign second = cur.second;

endmodule

// File: tb/tb_watch_counter.sv
// Directed bench for watch_counter with a per-cycle calendar reference model.
module tb_watch_counter;

  localparam int unsigned CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_time = 1'b0;
  logic [47:0] bin_time = '0;
  logic [7:0]  year, month, day, hour, minute, second;
  logic        sec_tick;

  int checks   = 0;
  int failures = 0;

  watch_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_time  (en_time),
    .bin_time (bin_time),
    .year     (year),
    .month    (month),
    .day      (day),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
    return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  function automatic int dim_of(input int m, input int y);
    int t[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && (y % 4) == 0) return 29;
    return t[m];
  endfunction

  // Reference model state: fields as integers plus cycles counted since release.
  int m_y, m_mo, m_d, m_h, m_mi, m_s;
  int m_run;
  bit m_tick;

  task automatic model_reset();
    m_y = 0; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
    m_run = 0; m_tick = 0;
  endtask

  task automatic model_load(input logic [47:0] b);
    m_y  = (b[47:40] > 99) ? 99 : int'(b[47:40]);
    m_mo = int'(b[39:32]);
    if (m_mo == 0) m_mo = 1;
    else if (m_mo > 12) m_mo = 12;
    m_d  = int'(b[31:24]);
    if (m_d == 0) m_d = 1;
    else if (m_d > dim_of(m_mo, m_y)) m_d = dim_of(m_mo, m_y);
    m_h  = (b[23:16] > 23) ? 23 : int'(b[23:16]);
    m_mi = (b[15:8]  > 59) ? 59 : int'(b[15:8]);
    m_s  = (b[7:0]   > 59) ? 59 : int'(b[7:0]);
    m_run = 0; m_tick = 0;
  endtask

  // Advance by one second using seconds-of-day arithmetic.
  task automatic model_advance();
    int sod;
    sod = m_h * 3600 + m_mi * 60 + m_s + 1;
    if (sod == 86400) begin
      sod = 0;
      m_d = m_d + 1;
      if (m_d > dim_of(m_mo, m_y)) begin
        m_d = 1;
        m_mo = m_mo + 1;
        if (m_mo > 12) begin
          m_mo = 1;
          m_y = (m_y + 1) % 100;
        end
      end
    end
    m_h  = sod / 3600;
    m_mi = (sod / 60) % 60;
    m_s  = sod % 60;
  endtask

  // Model update on the same edges the DUT uses.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else if (en_time) begin
      model_load(bin_time);
    end else begin
      m_run  = m_run + 1;
      m_tick = ((m_run % CLK_HZ) == 0);
      if (m_tick) model_advance();
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    logic [47:0] exp_cal;
    exp_cal = pack(m_y, m_mo, m_d, m_h, m_mi, m_s);
    checks++;
    if ({year, month, day, hour, minute, second} !== exp_cal) begin
      failures++;
      $display("FAIL model_cal t=%0t got %h want %h", $time,
               {year, month, day, hour, minute, second}, exp_cal);
    end
    checks++;
    if (sec_tick !== m_tick) begin
      failures++;
      $display("FAIL model_tick t=%0t got %b want %b", $time, sec_tick, m_tick);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_now(input string name, input logic [47:0] exp_cal, input logic exp_tick);
    checks++;
    if ({year, month, day, hour, minute, second} !== exp_cal) begin
      failures++;
      $display("FAIL %s cal got %h want %h", name,
               {year, month, day, hour, minute, second}, exp_cal);
    end
    checks++;
    if (sec_tick !== exp_tick) begin
      failures++;
      $display("FAIL %s tick got %b want %b", name, sec_tick, exp_tick);
    end
  endtask

  task automatic load_release(input logic [47:0] v);
    en_time  = 1'b1;
    bin_time = v;
    step();
    en_time  = 1'b0;
    bin_time = '0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) step();
    expect_now("reset", pack(0, 1, 1, 0, 0, 0), 1'b0);
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      expect_now($sformatf("run%0d", k), pack(0, 1, 1, 0, 0, k / 4), (k % 4) == 0);
    end

    load_release(pack(99, 12, 31, 23, 59, 59));
    expect_now("load_full", pack(99, 12, 31, 23, 59, 59), 1'b0);
    repeat (3) step();
    expect_now("wrap_pre", pack(99, 12, 31, 23, 59, 59), 1'b0);
    step();
    expect_now("wrap", pack(0, 1, 1, 0, 0, 0), 1'b1);

    load_release(pack(24, 2, 28, 23, 59, 59));
    repeat (4) step();
    expect_now("leap", pack(24, 2, 29, 0, 0, 0), 1'b1);

    load_release(pack(23, 2, 28, 23, 59, 59));
    repeat (4) step();
    expect_now("noleap", pack(23, 3, 1, 0, 0, 0), 1'b1);

    en_time  = 1'b1;
    bin_time = pack(120, 0, 40, 30, 60, 75);
    step();
    expect_now("clamp", pack(99, 1, 31, 23, 59, 59), 1'b0);
    bin_time = pack(1, 13, 31, 0, 0, 0);
    step();
    expect_now("clamp_feb_mo", pack(1, 12, 31, 0, 0, 0), 1'b0);
    bin_time = pack(21, 2, 30, 0, 0, 0);
    step();
    expect_now("clamp_feb", pack(21, 2, 28, 0, 0, 0), 1'b0);

    for (int i = 0; i < 10; i++) begin
      bin_time = pack(i * 10, i + 1, i + 10, i * 2, i * 6, i * 5);
      step();
      expect_now($sformatf("follow%0d", i), pack(i * 10, i + 1, i + 10, i * 2, i * 6, i * 5), 1'b0);
    end
    en_time  = 1'b0;
    bin_time = '0;
    repeat (3) step();
    expect_now("pre3", pack(90, 10, 19, 18, 54, 45), 1'b0);
    en_time  = 1'b1;
    bin_time = pack(10, 10, 10, 10, 10, 10);
    step();
    expect_now("load_wins", pack(10, 10, 10, 10, 10, 10), 1'b0);
    en_time  = 1'b0;
    bin_time = '0;
    repeat (4) step();
    expect_now("after_win", pack(10, 10, 10, 10, 10, 11), 1'b1);

    load_release(pack(5, 6, 15, 12, 34, 56));
    repeat (2) step();
    rst = 1'b0;
    #1;
    expect_now("async_rst", pack(0, 1, 1, 0, 0, 0), 1'b0);
    step();
    rst = 1'b1;
    repeat (3) step();
    expect_now("rst_pre", pack(0, 1, 1, 0, 0, 0), 1'b0);
    step();
    expect_now("rst_tick", pack(0, 1, 1, 0, 0, 1), 1'b1);
    repeat (8) step();
    expect_now("steady", pack(0, 1, 1, 0, 0, 3), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_counter.md
# watch_counter

Free-running calendar timekeeper. It advances year/month/day/hour/minute/second once per second, derived from the system clock, and reloads the whole calendar from the 48-bit packed time bus that the setting logic drives while its enable is high. It sits between the setting block and the display/formatting path. It is the consumer of `bin_time`/`en_time` and the producer of the `year`…`second` fields the setting block reads.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; must be ≥ 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous active-low reset.
- `en_time` input 1: load enable; while high, the calendar tracks `bin_time`.
- `bin_time` input 48: packed load value. Fields, all binary:
  - `[47:40]` year, 0–99, meaning 2000–2099.
  - `[39:32]` month.
  - `[31:24]` day.
  - `[23:16]` hour.
  - `[15:8]` minute.
  - `[7:0]` second.
- `year`, `month`, `day`, `hour`, `minute`, `second` output 8 each: current calendar, registered, binary.
- `sec_tick` output 1: one-cycle pulse, high in the cycle the counted time advanced.

## Operation
- Reset values:
  - Calendar: year 0, month 1, day 1, hour 0, minute 0, second 0.
  - `sec_tick` 0.
  - Prescaler 0.
- Prescaler `pre`, width $clog2(CLK_HZ):
  - Counts 0..CLK_HZ-1 while `en_time`=0.
  - `pre`==CLK_HZ-1 is a tick: `pre` wraps to 0 and the calendar advances by one second.
- Advance cascade, all in the same edge:
  - second 59→0 carries to minute.
  - minute 59→0 carries to hour.
  - hour 23→0 carries to day.
  - day == dim(month, year) → 1 carries to month.
  - month 12→1 carries to year.
  - year 99→0 (wrap, no carry-out).
- dim (days in month):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Feb: 29 if year[1:0]==0, else 28.
- Load, `en_time`=1:
  - Every cycle the calendar registers take the clamped `bin_time` fields.
  - `pre` is held at 0; `sec_tick` stays 0. Loading has priority over a tick.
- Clamping of load fields, applied in this order:
  - second, minute >59 → 59.
  - hour >23 → 23.
  - year >99 → 99.
  - month 0 → 1; month >12 → 12.
  - day 0 → 1; day > dim(clamped month, clamped year) → that dim.
- Release: after `en_time` falls, counting restarts from `pre`=0. The first advance comes exactly CLK_HZ cycles after the first cycle with `en_time`=0.
- No illegal internal state is reachable. If one occurs anyway (e.g. day > dim), the next tick treats day ≥ dim as the rollover condition.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- Load latency: a `bin_time` value sampled at edge N appears on the outputs after edge N.
- Tick:
  - `sec_tick`=1 for exactly the one cycle following the advancing edge, coincident with the new calendar values.
  - Period is exactly CLK_HZ cycles in steady state.
- Full cascade (e.g. 99-12-31 23:59:59 → 00-01-01 00:00:00) completes in one edge.
- Reset:
  - Asserting `rst` at any time, including mid-count or mid-load, forces all reset values immediately.
  - After deassertion, the first tick occurs CLK_HZ edges later.
- `en_time` rising in the same cycle that `pre`==CLK_HZ-1: the load wins, no advance, `sec_tick`=0.

## Structure
- Shared package `watch_pkg`, for reuse by the setting and display blocks:
  - Field constants `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23, `MONTH_MAX`=12, `YEAR_MAX`=99.
  - Reset constants for the calendar.
  - Bit-slice constants for `bin_time` fields.
- Sub-module `month_days`: combinational.
  - Inputs month[7:0], year[7:0]; output dim[4:0].
  - Instantiated twice: once for the current calendar (advance), once for the clamped load values.
- Remainder (prescaler, cascade, clamp, load mux) lives in `watch_counter`.

## Test plan
All scenarios use CLK_HZ=4.
- Reset, then run 12 cycles:
  - Outputs are 00-01-01 00:00:00 while `rst` is low.
  - `sec_tick` pulses on cycles 4, 8 and 12; second reads 1, 2, 3.
- Load 99-12-31 23:59:59 with `en_time` for 1 cycle, then release:
  - After 4 cycles the outputs read 00-01-01 00:00:00.
  - `sec_tick`=1 in that cycle.
- Leap-year handling:
  - Load 24-02-28 23:59:59, one tick → 24-02-29 00:00:00.
  - Load 23-02-28 23:59:59, one tick → 23-03-01 00:00:00.
- Clamping: load year 120, month 0, day 40, hour 30, minute 60, second 75 → 99-01-31 23:59:59.
- Load priority:
  - Hold `en_time` high for 10 cycles with `bin_time` changing every cycle: outputs follow with 1-cycle latency and `sec_tick` stays 0.
  - Assert `en_time` exactly when `pre`==3: no advance occurs.
- Mid-count reset:
  - Pull `rst` low at `pre`==2 with the calendar at 05-06-15 12:34:56: outputs go to reset values immediately.
  - After release, the first tick arrives 4 cycles later.
